// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive front end.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int baud_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head data is valid whenever o_empty is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // When full, a simultaneous pop frees the head slot that the write pointer now aliases.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampled) feeding a receive FIFO with ready/valid output and rts flow control.
// Define UART_RX_PARITY_EN for 8E1 framing with parity checking; otherwise frames are 8N1.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for falling edge
// ST_START     | verifying start bit at mid-bit
// ST_DATA      | sampling 8 data bits, LSB first
// ST_PARITY    | sampling even-parity bit (parity build only)
// ST_STOP      | sampling stop bit, push or flag error
// ST_WAIT_IDLE | after framing error, wait for 16 high ticks
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_THRESH = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rts,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overflow
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DW-1:0] DIV_RELOAD = DW'(DIV - 1);
  localparam logic [3:0]    MID_TICK   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    LAST_TICK  = 4'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] THRESH     = CW'(RTS_THRESH);

  rx_state_e     r_state, w_state_nxt;
  logic          r_rxd_meta, r_rxd_sync, r_rxd_prev;
  logic [DW-1:0] r_div_cnt;
  logic [3:0]    r_tick_cnt, w_tick_nxt;
  logic [2:0]    r_bit_cnt, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_push, w_push_set;
  logic          r_ferr, w_ferr_set;
  logic          r_overflow;
  logic          r_rts;
  logic          w_tick, w_start_edge, w_div_reload;
  logic          w_pop, w_full, w_empty;
  logic [CW-1:0] w_count;
`ifdef UART_RX_PARITY_EN
  logic          r_par_bad, w_par_bad_nxt;
  logic          r_perr, w_perr_set;
`endif

  assign w_start_edge = r_rxd_prev & ~r_rxd_sync;
  assign w_tick       = (r_div_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  // Reload on start detect so every frame's sample points are measured from its own edge.
  always_ff @(posedge clk) begin
    if (rst)                         r_div_cnt <= '0;
    else if (w_div_reload || w_tick) r_div_cnt <= DIV_RELOAD;
    else                             r_div_cnt <= r_div_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_push     <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_push     <= w_push_set;
      r_ferr     <= w_ferr_set;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= w_par_bad_nxt;
      r_perr     <= w_perr_set;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_push_set    = 1'b0;
    w_ferr_set    = 1'b0;
    w_div_reload  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_perr_set    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt  = ST_START;
          w_tick_nxt   = '0;
          w_div_reload = 1'b1;
`ifdef UART_RX_PARITY_EN
          w_par_bad_nxt = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_tick_cnt == MID_TICK) begin
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = r_rxd_sync ? ST_IDLE : ST_DATA;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_tick_nxt = r_tick_cnt + 1'b1;
          if (r_tick_cnt == LAST_TICK) begin
            w_shift_nxt = {r_rxd_sync, r_shift[7:1]};
            w_bit_nxt   = r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_tick_nxt = r_tick_cnt + 1'b1;
          if (r_tick_cnt == LAST_TICK) begin
            w_par_bad_nxt = (^r_shift) ^ r_rxd_sync;
            w_state_nxt   = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          w_tick_nxt = r_tick_cnt + 1'b1;
          if (r_tick_cnt == LAST_TICK) begin
            w_tick_nxt = '0;
`ifdef UART_RX_PARITY_EN
            // A parity failure masks any stop-bit error for the same frame.
            if (r_par_bad) begin
              w_perr_set  = 1'b1;
              w_state_nxt = r_rxd_sync ? ST_IDLE : ST_WAIT_IDLE;
            end else
`endif
            if (r_rxd_sync) begin
              w_push_set  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_ferr_set  = 1'b1;
              w_state_nxt = ST_WAIT_IDLE;
            end
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (!r_rxd_sync) begin
          w_tick_nxt = '0;
        end else if (w_tick) begin
          w_tick_nxt = r_tick_cnt + 1'b1;
          if (r_tick_cnt == LAST_TICK) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_pop = m_valid & m_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_data  (r_shift),
    .o_data  (m_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_rts      <= 1'b1;
    end else begin
      if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
      r_rts <= (w_count >= THRESH);
    end
  end

  assign m_valid   = ~w_empty;
  assign rts       = r_rts;
  assign overflow  = r_overflow;
  assign frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule
